// File: rtl/result_uart_tx.sv
// Serialises a 32-bit result word as "XXXXXXXX\r\n" (uppercase ASCII hex, MSB nibble first)
// over an 8N1 UART line. Every output is taken straight from a register.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] TIMER_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_reg,    state_next;
    logic [15:0] timer_reg,    timer_next;
    logic [2:0]  bit_idx_reg,  bit_idx_next;
    logic [3:0]  byte_idx_reg, byte_idx_next;
    logic [31:0] data_reg,     data_next;
    logic        tx_reg,       tx_next;
    logic        busy_reg,     busy_next;
    logic        done_reg,     done_next;
    logic        overrun_reg,  overrun_next;

    logic [3:0]  nibble [8];
    logic [7:0]  cur_char;
    logic [2:0]  bit_idx_inc;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    // nibble[k] is the k-th character of the hex text, most significant first
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nibble
            assign nibble[gi] = data_reg[31 - 4*gi -: 4];
        end
    endgenerate

    always_comb begin
        cur_char = 8'h0A;
        if (byte_idx_reg == 4'd8)
            cur_char = 8'h0D;
        else if (byte_idx_reg < 4'd8)
            cur_char = hex_ascii(nibble[byte_idx_reg[2:0]]);
    end

    assign bit_idx_inc = bit_idx_reg + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            data_reg     <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            data_reg     <= data_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            overrun_reg  <= overrun_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        data_next     = data_reg;
        tx_next       = tx_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        overrun_next  = overrun_reg | (load & busy_reg);

        if (state_reg == IDLE) begin
            tx_next = 1'b1;
            if (load) begin
                // start bit of byte 0 goes out on the accepting edge
                state_next    = START;
                timer_next    = '0;
                bit_idx_next  = '0;
                byte_idx_next = '0;
                data_next     = data;
                tx_next       = 1'b0;
                busy_next     = 1'b1;
            end
        end else if (timer_reg != TIMER_MAX) begin
            timer_next = timer_reg + 16'd1;
        end else begin
            timer_next = '0;
            case (state_reg)
                START: begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = cur_char[0];
                end
                DATA: begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        tx_next      = cur_char[bit_idx_inc];
                    end
                end
                STOP: begin
                    if (byte_idx_reg == 4'd9) begin
                        state_next    = IDLE;
                        byte_idx_next = '0;
                        tx_next       = 1'b1;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end else begin
                        state_next    = START;
                        byte_idx_next = byte_idx_reg + 4'd1;
                        tx_next       = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign tx      = tx_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx at CLKS_PER_BIT=4: every cycle of tx/busy/done is compared with
// a timeline computed from the message rules, and the line is also decoded back into bytes.
module tb_result_uart_tx;

    localparam int CPB = 4;
    localparam int MSG = 100 * CPB;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] data;
    logic        tx;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .data(data),
        .tx(tx),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Character k of the message for word d
    function automatic logic [7:0] msg_byte(input logic [31:0] d, input int k);
        int nib;
        if (k == 8) return 8'h0D;
        if (k == 9) return 8'h0A;
        nib = int'((d >> (28 - 4*k)) & 32'hF);
        if (nib < 10) return 8'(48 + nib);
        return 8'(55 + nib);
    endfunction

    // Expected line level t cycles after the accept edge
    function automatic logic exp_bit(input logic [31:0] d, input int t);
        int b;
        int p;
        logic [7:0] c;
        b = t / (10*CPB);
        p = (t % (10*CPB)) / CPB;
        c = msg_byte(d, b);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return c[p-1];
    endfunction

    // Called at accept edge + 1; returns at accept edge + MSG + 1 (done cycle)
    task automatic check_message(input logic [31:0] d, input logic [7:0] exp_b [10],
                                 input logic exp_ovr, input string name);
        int bad;
        int first_bad;
        logic [7:0] rx [10];
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < 10; k++) rx[k] = 8'h00;
        for (int t = 0; t < MSG; t++) begin
            int p;
            p = (t % (10*CPB)) / CPB;
            if (p >= 1 && p <= 8 && (t % CPB) == CPB/2) rx[t / (10*CPB)][p-1] = tx;
            if (tx !== exp_bit(d, t) || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                if (first_bad < 0) first_bad = t;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s waveform: %0d bad cycles, first at offset %0d, required 0", name, bad, first_bad);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (rx[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL %s byte%0d: got %02h required %02h", name, k, rx[k], exp_b[k]);
            end
        end
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s end: tx/busy/done got %b%b%b required 101", name, tx, busy, done);
        end
        checks++;
        if (overrun !== exp_ovr) begin
            errors++;
            $display("FAIL %s overrun: got %b required %b", name, overrun, exp_ovr);
        end
        $display("message %s data=%08h checked", name, d);
    endtask

    task automatic model_bytes(input logic [31:0] d, output logic [7:0] b [10]);
        for (int k = 0; k < 10; k++) b[k] = msg_byte(d, k);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_load(input logic [31:0] d);
        load = 1'b1;
        data = d;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load = 1'b0;
        data = '0;
        #3;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset: tx/busy/done/overrun got %b%b%b%b required 1000", tx, busy, done, overrun);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("reset state checked");
    endtask

    task automatic test_hex_basic();
        logic [7:0] b [10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h44, 8'h32, 8'h0D, 8'h0A};
        start_load(32'h000000D2);
        check_message(32'h000000D2, b, 1'b0, "d2");
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL d2 after-done: done/busy/tx got %b%b%b required 001", done, busy, tx);
        end
    endtask

    task automatic test_deadbeef();
        logic [7:0] b [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        start_load(32'hDEADBEEF);
        check_message(32'hDEADBEEF, b, 1'b0, "deadbeef");
        @(posedge clk);
        #1;
    endtask

    task automatic test_data_ignored();
        logic [7:0] b [10] = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h46, 8'h30, 8'h30, 8'h44, 8'h0D, 8'h0A};
        start_load(32'hCAFEF00D);
        fork
            check_message(32'hCAFEF00D, b, 1'b0, "cafef00d");
            begin
                for (int i = 0; i < MSG; i++) begin
                    data = $urandom;
                    @(posedge clk);
                    #1;
                end
            end
        join
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0] b [10];
        d = $urandom;
        start_load(d);
        for (int i = 0; i < 4; i++) begin
            model_bytes(d, b);
            check_message(d, b, 1'b0, $sformatf("rand%0d", i));
            if (i < 3) begin
                d = $urandom;
                start_load(d);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b idle: done/busy got %b%b required 00", done, busy);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] b [10];
        model_bytes(32'h12345678, b);
        start_load(32'h12345678);
        fork
            check_message(32'h12345678, b, 1'b1, "overrun");
            begin
                repeat (49) @(posedge clk);
                #1;
                checks++;
                if (overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL overrun early: got %b required 0", overrun);
                end
                load = 1'b1;
                data = 32'hFFFFFFFF;
                @(posedge clk);
                #1;
                load = 1'b0;
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun set: got %b required 1", overrun);
                end
            end
        join
        @(posedge clk);
        #1;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun sticky: got %b required 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [10];
        start_load(32'h9ABCDEF0);
        repeat (131) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset-mid: tx/busy/overrun/done got %b%b%b%b required 1000", tx, busy, overrun, done);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset-hold: tx/busy got %b%b required 10", tx, busy);
        end
        rst = 1'b0;
        model_bytes(32'h00000001, b);
        start_load(32'h00000001);
        check_message(32'h00000001, b, 1'b0, "after-reset");
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_held();
        logic [31:0] d1;
        logic [31:0] d2;
        logic [7:0] b [10];
        d1 = $urandom;
        d2 = $urandom;
        do_reset();
        load = 1'b1;
        data = d1;
        @(posedge clk);
        #1;
        data = d2;
        model_bytes(d1, b);
        check_message(d1, b, 1'b1, "held1");
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            errors++;
            $display("FAIL held re-accept: busy/tx got %b%b required 10", busy, tx);
        end
        load = 1'b0;
        model_bytes(d2, b);
        check_message(d2, b, 1'b1, "held2");
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_hex_basic();
        test_deadbeef();
        test_data_ignored();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_load_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port load  input  1  request to transmit data; sampled on rising clk.
REQ-005 SHALL have port data  input  32  core result value (the word captured on ecall); sampled when load is accepted.
REQ-006 SHALL have port tx  output  1  UART serial line, idle high.
REQ-007 SHALL have port busy  output  1  high while a message is in flight.
REQ-008 SHALL have port done  output  1  single-cycle pulse on message completion.
REQ-009 SHALL have port overrun  output  1  sticky flag: a load arrived while busy.

Function
REQ-010 SHALL accept load on a rising edge only when busy was 0 before that edge; on acceptance, latch data internally and set busy=1 at that edge.
REQ-011 SHALL transmit a 10-byte message per accepted load: bytes 0..7 = ASCII hex of data nibbles, most significant first (byte k from data[31-4k:28-4k]); byte 8 = 0x0D; byte 9 = 0x0A.
REQ-012 SHALL encode nibbles 0-9 as 0x30-0x39 and 10-15 as uppercase 0x41-0x46.
REQ-013 SHALL frame each byte as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 SHALL hold every bit on tx for exactly CLKS_PER_BIT cycles, driving tx from a register (no combinational path from load/data to tx).
REQ-015 SHALL begin the start bit of byte 0 at the edge that accepts load (tx=0 from that edge).
REQ-016 SHALL start the next byte's start bit immediately after the previous stop bit, with no idle gap; total message length exactly 100*CLKS_PER_BIT cycles.
REQ-017 SHALL use state machine IDLE -> START -> DATA (bit index 0..7) -> STOP -> START (byte index < 9) or IDLE (byte index = 9); bit timer counts 0..CLKS_PER_BIT-1 and advances state on terminal count.
REQ-018 SHALL drop busy to 0 and pulse done=1 for one cycle at the edge ending the stop bit of byte 9 (edge A+100*CLKS_PER_BIT, where A is the accept edge); tx=1 from then on.
REQ-019 SHALL ignore load while busy=1 (latched data unchanged, message uninterrupted) and set overrun=1 at that edge; overrun stays 1 until reset.
REQ-020 SHALL accept a load asserted in the cycle after done, i.e. earliest re-accept edge A+100*CLKS_PER_BIT+1.
REQ-021 SHALL ignore changes on data after the accept edge.

Reset
REQ-022 SHALL on rst=1, asynchronously and without waiting for clk: tx=1, busy=0, done=0, overrun=0, state IDLE, byte/bit indices, timer and latched data = 0.
REQ-023 SHALL abort any message in progress on reset, including mid-bit; no partial byte resumes after release.
REQ-024 SHALL accept load on the first rising edge with rst=0.

Verification (CLKS_PER_BIT=4)
REQ-025 SHALL pass: load data=0x000000D2 -> tx decodes "000000D2" 0x0D 0x0A (bytes 30 30 30 30 30 30 44 32 0D 0A), busy high 400 cycles, one done pulse.
REQ-026 SHALL pass: load data=0xDEADBEEF -> bytes 44 45 41 44 42 45 45 46 0D 0A; each bit exactly 4 cycles; stop bit followed directly by next start bit.
REQ-027 SHALL pass: load 0x12345678, then load 0xFFFFFFFF 50 cycles later -> message "12345678\r\n" unchanged, overrun=1 from that edge until reset.
REQ-028 SHALL pass: rst asserted mid-data-bit of byte 3 between clock edges -> tx=1, busy=0 immediately; after release, load 0x00000001 -> clean "00000001\r\n".
REQ-029 SHALL pass: load held continuously high -> accepted at A, then again at A+401; overrun=1; two complete back-to-back messages.
REQ-030 SHALL pass: data changed every cycle after acceptance of 0xCAFEF00D -> transmitted bytes still 43 41 46 45 46 30 30 44 0D 0A.
